parking_exit_ctrl: RTL and testbench

PARKING_EXIT_CTRL -- requirements
Module: parking_exit_ctrl

---
 rtl/parking_pkg.sv | 28 ++
 rtl/seg7_decode.sv | 27 ++
 rtl/parking_exit_ctrl.sv | 118 +++++++++++
 tb/tb_parking_exit_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared definitions for the parking exit controller: FSM states, exit code
// and active-low seven-segment patterns (bit order {g,f,e,d,c,b,a}).
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_CODE = 3'd1,
    WRONG     = 3'd2,
    OPEN      = 3'd3,
    EMPTY_ERR = 3'd4
  } state_t;

  localparam logic [1:0] EXIT_CODE_1 = 2'b10;
  localparam logic [1:0] EXIT_CODE_2 = 2'b01;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// Decimal digit to active-low seven-segment decoder; out-of-range codes
// blank the display.
module seg7_decode
  import parking_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/parking_exit_ctrl.sv
// Exit barrier controller with occupancy tracking and free-slot display.
// Define PARKING_EXIT_HEX_EN to drive HEX_FREE from the seven-segment decoder.
//
// state     | meaning
// IDLE      | barrier down, waiting for a car at the exit
// WAIT_CODE | code-entry window, codes sampled in the last cycle
// WRONG     | wrong code shown, alarm on until a matching code appears
// OPEN      | barrier raised; car counted out in the last cycle
// EMPTY_ERR | exit attempt with an empty lot, alarm until the sensor clears
module parking_exit_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY    = 8,
  parameter int WAIT_CYCLES = 3,
  parameter int OPEN_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_exit,
  input  logic       car_in,
  input  logic [1:0] exit_code_1,
  input  logic [1:0] exit_code_2,
  output logic       GATE_OPEN,
  output logic       ALARM_LED,
  output logic [3:0] occupancy,
  output logic       FULL,
  output logic [6:0] HEX_FREE
);

  localparam logic [3:0] CAP_L     = 4'(CAPACITY);
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] OPEN_LAST = 4'(OPEN_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] occ_q, occ_d;
  logic       gate_q, alarm_q;
  logic       code_ok;
  logic       occ_dec;

  assign code_ok = (exit_code_1 == EXIT_CODE_1) && (exit_code_2 == EXIT_CODE_2);

  always_comb begin
    state_d = state_q;
    occ_dec = 1'b0;
    case (state_q)
      IDLE: begin
        if (sensor_exit) state_d = (occ_q != 4'd0) ? WAIT_CODE : EMPTY_ERR;
      end
      WAIT_CODE: begin
        if (cnt_q == WAIT_LAST) state_d = code_ok ? OPEN : WRONG;
      end
      WRONG: begin
        if (code_ok) state_d = OPEN;
      end
      OPEN: begin
        if (cnt_q == OPEN_LAST) begin
          occ_dec = (occ_q != 4'd0);
          state_d = sensor_exit ? WAIT_CODE : IDLE;
        end
      end
      EMPTY_ERR: begin
        if (!sensor_exit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter restarts from zero on every state change, including OPEN -> WAIT_CODE.
  always_comb begin
    cnt_d = 4'd0;
    if ((state_d == state_q) && ((state_q == WAIT_CODE) || (state_q == OPEN)))
      cnt_d = cnt_q + 4'd1;
  end

  // A car arriving as one leaves nets to zero, even when the lot is full.
  always_comb begin
    occ_d = occ_q;
    if (occ_dec && !car_in)
      occ_d = occ_q - 4'd1;
    else if (!occ_dec && car_in && (occ_q != CAP_L))
      occ_d = occ_q + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      occ_q   <= 4'd0;
      gate_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      occ_q   <= occ_d;
      gate_q  <= (state_d == OPEN);
      alarm_q <= (state_d == WRONG) || (state_d == EMPTY_ERR);
    end
  end

  assign GATE_OPEN = gate_q;
  assign ALARM_LED = alarm_q;
  assign occupancy = occ_q;
  assign FULL      = (occ_q == CAP_L);

`ifdef PARKING_EXIT_HEX_EN
  logic [3:0] free_slots;
  assign free_slots = CAP_L - occ_q;

  seg7_decode u_seg7 (
    .digit_i (free_slots),
    .seg_o   (HEX_FREE)
  );
`else
  assign HEX_FREE = SEG_BLANK;
`endif

endmodule

// File: tb/tb_parking_exit_ctrl.sv
// Directed bench for parking_exit_ctrl: a per-cycle vector table followed by
// hand-written sequences for saturation, tailgating and reset mid-OPEN.
module tb_parking_exit_ctrl;

  logic       clk;
  logic       reset;
  logic       sensor_exit;
  logic       car_in;
  logic [1:0] exit_code_1;
  logic [1:0] exit_code_2;
  logic       GATE_OPEN;
  logic       ALARM_LED;
  logic [3:0] occupancy;
  logic       FULL;
  logic [6:0] HEX_FREE;

  int n_checks = 0;
  int n_fail   = 0;

  parking_exit_ctrl #(
    .CAPACITY    (8),
    .WAIT_CYCLES (3),
    .OPEN_CYCLES (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sensor_exit (sensor_exit),
    .car_in      (car_in),
    .exit_code_1 (exit_code_1),
    .exit_code_2 (exit_code_2),
    .GATE_OPEN   (GATE_OPEN),
    .ALARM_LED   (ALARM_LED),
    .occupancy   (occupancy),
    .FULL        (FULL),
    .HEX_FREE    (HEX_FREE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       sen;
    logic       car;
    logic [1:0] c1;
    logic [1:0] c2;
    logic       gate;
    logic       alarm;
    logic [3:0] occ;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic sen, logic car, logic [1:0] c1,
                              logic [1:0] c2, logic gate, logic alarm, logic [3:0] occ);
    vec_t v;
    v.rst = rst; v.sen = sen; v.car = car; v.c1 = c1; v.c2 = c2;
    v.gate = gate; v.alarm = alarm; v.occ = occ;
    return v;
  endfunction

  function automatic logic [6:0] exp_hex(logic [3:0] occ);
    logic [6:0] pats [0:9];
    int free;
    pats[0] = 7'b1000000; pats[1] = 7'b1111001; pats[2] = 7'b0100100;
    pats[3] = 7'b0110000; pats[4] = 7'b0011001; pats[5] = 7'b0010010;
    pats[6] = 7'b0000010; pats[7] = 7'b1111000; pats[8] = 7'b0000000;
    pats[9] = 7'b0010000;
    free = 8 - int'(occ);
`ifdef PARKING_EXIT_HEX_EN
    return (free >= 0 && free <= 9) ? pats[free] : 7'b1111111;
`else
    return (free >= 0) ? 7'b1111111 : pats[0];
`endif
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(string tag, logic gate, logic alarm, logic [3:0] occ);
    chk({tag, " gate"},  {7'd0, GATE_OPEN}, {7'd0, gate});
    chk({tag, " alarm"}, {7'd0, ALARM_LED}, {7'd0, alarm});
    chk({tag, " occ"},   {4'd0, occupancy}, {4'd0, occ});
    chk({tag, " full"},  {7'd0, FULL},      {7'd0, (occ == 4'd8)});
    chk({tag, " hex"},   {1'b0, HEX_FREE},  {1'b0, exp_hex(occ)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic sen, logic car, logic [1:0] c1, logic [1:0] c2);
    sensor_exit = sen;
    car_in      = car;
    exit_code_1 = c1;
    exit_code_2 = c2;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 2'b00);

    // rst sen car c1 c2 | gate alarm occ
    vecs.push_back(mk(0, 0, 1, 2'b00, 2'b00, 0, 0, 4'd1));
    vecs.push_back(mk(0, 0, 1, 2'b00, 2'b00, 0, 0, 4'd2));
    vecs.push_back(mk(0, 0, 1, 2'b00, 2'b00, 0, 0, 4'd3));
    vecs.push_back(mk(0, 1, 0, 2'b10, 2'b01, 0, 0, 4'd3));
    vecs.push_back(mk(0, 1, 0, 2'b10, 2'b01, 0, 0, 4'd3));
    vecs.push_back(mk(0, 1, 0, 2'b10, 2'b01, 0, 0, 4'd3));
    vecs.push_back(mk(0, 1, 0, 2'b10, 2'b01, 1, 0, 4'd3));
    vecs.push_back(mk(0, 0, 0, 2'b10, 2'b01, 1, 0, 4'd3));
    vecs.push_back(mk(0, 0, 0, 2'b10, 2'b01, 1, 0, 4'd3));
    vecs.push_back(mk(0, 0, 0, 2'b10, 2'b01, 1, 0, 4'd3));
    vecs.push_back(mk(0, 0, 0, 2'b10, 2'b01, 0, 0, 4'd2));
    vecs.push_back(mk(1, 0, 0, 2'b00, 2'b00, 0, 0, 4'd0));
    vecs.push_back(mk(0, 0, 1, 2'b00, 2'b00, 0, 0, 4'd1));
    vecs.push_back(mk(0, 1, 0, 2'b01, 2'b10, 0, 0, 4'd1));
    vecs.push_back(mk(0, 1, 0, 2'b01, 2'b10, 0, 0, 4'd1));
    vecs.push_back(mk(0, 1, 0, 2'b01, 2'b10, 0, 0, 4'd1));
    vecs.push_back(mk(0, 1, 0, 2'b01, 2'b10, 0, 1, 4'd1));
    vecs.push_back(mk(0, 1, 0, 2'b01, 2'b10, 0, 1, 4'd1));
    vecs.push_back(mk(0, 1, 0, 2'b10, 2'b01, 1, 0, 4'd1));
    vecs.push_back(mk(0, 0, 0, 2'b10, 2'b01, 1, 0, 4'd1));
    vecs.push_back(mk(0, 0, 0, 2'b10, 2'b01, 1, 0, 4'd1));
    vecs.push_back(mk(0, 0, 0, 2'b10, 2'b01, 1, 0, 4'd1));
    vecs.push_back(mk(0, 0, 0, 2'b10, 2'b01, 0, 0, 4'd0));
    vecs.push_back(mk(0, 1, 0, 2'b00, 2'b00, 0, 1, 4'd0));
    vecs.push_back(mk(0, 1, 0, 2'b00, 2'b00, 0, 1, 4'd0));
    vecs.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 4'd0));

    #2;
    chk_all("reset", 1'b0, 1'b0, 4'd0);
    step();
    reset = 1'b0;

    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      drive(vecs[i].sen, vecs[i].car, vecs[i].c1, vecs[i].c2);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].gate, vecs[i].alarm, vecs[i].occ);
    end
    reset = 1'b0;

    // Nine arrivals against capacity 8 saturate at 8.
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b1, 2'b00, 2'b00);
      step();
    end
    chk_all("sat", 1'b0, 1'b0, 4'd8);

    // Exit while full with an arrival on the decrement cycle.
    drive(1'b1, 1'b0, 2'b10, 2'b01);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("full_wait%0d", i), 1'b0, 1'b0, 4'd8);
      drive(1'b0, 1'b0, 2'b10, 2'b01);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      chk_all($sformatf("full_open%0d", i), 1'b1, 1'b0, 4'd8);
    end
    drive(1'b0, 1'b1, 2'b10, 2'b01);
    step();
    chk_all("full_swap", 1'b0, 1'b0, 4'd8);
    drive(1'b0, 1'b0, 2'b10, 2'b01);

    // Tailgate: sensor stays high through OPEN, so WAIT_CODE restarts.
    drive(1'b1, 1'b0, 2'b10, 2'b01);
    for (int i = 0; i < 7; i++) step();
    chk_all("tg_open_last", 1'b1, 1'b0, 4'd8);
    step();
    chk_all("tg_rewait0", 1'b0, 1'b0, 4'd7);
    step();
    chk_all("tg_rewait1", 1'b0, 1'b0, 4'd7);
    step();
    chk_all("tg_rewait2", 1'b0, 1'b0, 4'd7);
    step();
    chk_all("tg_reopen", 1'b1, 1'b0, 4'd7);
    step();
    chk_all("tg_open1", 1'b1, 1'b0, 4'd7);

    // Reset mid-OPEN clears outputs without waiting for an edge.
    #1;
    reset = 1'b1;
    #1;
    chk_all("rst_mid_open", 1'b0, 1'b0, 4'd0);
    drive(1'b0, 1'b0, 2'b00, 2'b00);
    step();
    reset = 1'b0;
    step();
    step();
    chk_all("post_reset", 1'b0, 1'b0, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
